// File: rtl/readout_frame_packer.sv
// readout_frame_packer
//   Drains bytes from the merged lane readout buffer and packs them into
//   packets on a 32-bit AXI-Stream. Each packet starts with a header word
//   {8'hA5, seq, len}. Payload bytes follow, little-endian, four per word.
//   A packet is started when a full payload is available, when partial data
//   has waited TIMEOUT_CYCLES, or when cfg_flush is high.
//
//   Optional build macro: READOUT_PACKER_CHECKSUM_EN
//     When defined, every packet ends with a trailer word {8'h5A, seq, sum},
//     where sum is the 16-bit sum of the payload bytes. That trailer carries
//     tlast in place of the last payload word.
//
// Ports
//   clk_core, clk_core_resn   core clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready  byte stream from the readout buffer
//   s_data_count              bytes currently held in the readout buffer
//   m_axis_tdata/tkeep/tvalid/tready/tlast  packed 32-bit output stream
//   cfg_enable                allow new packets to start
//   cfg_flush                 force a packet whenever data is waiting
//   status_busy               high whenever a packet is in progress
//   stat_packet_count         completed packets (wraps)
module readout_frame_packer #(
  parameter int MAX_PAYLOAD_BYTES = 64,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int SEQ_WIDTH         = 8
) (
  input  logic        clk_core,
  input  logic        clk_core_resn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_data_count,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        cfg_enable,
  input  logic        cfg_flush,
  output logic        status_busy,
  output logic [31:0] stat_packet_count
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [31:0]       MAX_BYTES = 32'(MAX_PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_GATHER  = 3'd2,
`ifdef READOUT_PACKER_CHECKSUM_EN
    ST_EMIT    = 3'd3,
    ST_TRAILER = 3'd4
`else
    ST_EMIT    = 3'd3
`endif
  } state_t;

  // Packet length is the buffer fill, clamped to one full payload.
  function automatic logic [15:0] clamp_len(input logic [31:0] count);
    if (count >= MAX_BYTES) clamp_len = MAX_BYTES[15:0];
    else                    clamp_len = count[15:0];
  endfunction

  // Idle timeout counter increment, saturating at the limit.
  function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] cnt);
    if (cnt >= TMO_LIMIT) tmo_sat_inc = TMO_LIMIT;
    else                  tmo_sat_inc = cnt + TMO_W'(1);
  endfunction

  function automatic logic [3:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd1:    keep_mask = 4'h1;
      3'd2:    keep_mask = 4'h3;
      3'd3:    keep_mask = 4'h7;
      3'd4:    keep_mask = 4'hF;
      default: keep_mask = 4'h0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [15:0]            remaining_q, remaining_d;
  logic [2:0]             collected_q, collected_d;
  logic [31:0]            word_q, word_d;
  logic [31:0]            m_tdata_q, m_tdata_d;
  logic [3:0]             m_tkeep_q, m_tkeep_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [31:0]            stat_q, stat_d;
`ifdef READOUT_PACKER_CHECKSUM_EN
  logic [15:0]            sum_q, sum_d;
`endif

  logic        has_data;
  logic        start;
  logic [15:0] len_new;
  logic [31:0] lane;

  assign has_data = (s_data_count != 32'd0);
  assign start    = cfg_enable &&
                    ((s_data_count >= MAX_BYTES) ||
                     ((tmo_q >= TMO_LIMIT) && has_data) ||
                     (cfg_flush && has_data));
  assign len_new  = clamp_len(s_data_count);
  // Incoming byte placed in its little-endian lane.
  assign lane     = {24'h000000, s_axis_tdata} << {collected_q[1:0], 3'b000};

  assign s_axis_tready     = (state_q == ST_GATHER) && (collected_q < 3'd4) &&
                             (remaining_q != 16'd0);
  assign status_busy       = (state_q != ST_IDLE);
  assign m_axis_tdata      = m_tdata_q;
  assign m_axis_tkeep      = m_tkeep_q;
  assign m_axis_tvalid     = m_tvalid_q;
  assign m_axis_tlast      = m_tlast_q;
  assign stat_packet_count = stat_q;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    tmo_d       = '0;
    remaining_d = remaining_q;
    collected_d = collected_q;
    word_d      = word_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    stat_d      = stat_q;
`ifdef READOUT_PACKER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = len_new;
          collected_d = 3'd0;
          word_d      = 32'd0;
          m_tdata_d   = {8'hA5, seq_q, len_new};
          m_tkeep_d   = 4'hF;
          m_tlast_d   = 1'b0;
          m_tvalid_d  = 1'b1;
          state_d     = ST_HEADER;
`ifdef READOUT_PACKER_CHECKSUM_EN
          sum_d       = 16'd0;
`endif
        end else if (!has_data) begin
          tmo_d = '0;
        end else if (s_data_count < MAX_BYTES) begin
          tmo_d = tmo_sat_inc(tmo_q);
        end else begin
          // Full payload waiting but not enabled: hold the count.
          tmo_d = tmo_q;
        end
      end

      ST_HEADER: begin
        if (m_axis_tready) begin
          m_tvalid_d = 1'b0;
          m_tdata_d  = 32'd0;
          m_tkeep_d  = 4'h0;
          state_d    = ST_GATHER;
        end
      end

      ST_GATHER: begin
        if (s_axis_tready && s_axis_tvalid) begin
          collected_d = collected_q + 3'd1;
          remaining_d = remaining_q - 16'd1;
          word_d      = word_q | lane;
`ifdef READOUT_PACKER_CHECKSUM_EN
          sum_d       = sum_q + {8'h00, s_axis_tdata};
`endif
          // Word complete: load the output register with the new word.
          if ((collected_d == 3'd4) || (remaining_d == 16'd0)) begin
            m_tdata_d  = word_d;
            m_tkeep_d  = keep_mask(collected_d);
`ifdef READOUT_PACKER_CHECKSUM_EN
            m_tlast_d  = 1'b0;
`else
            m_tlast_d  = (remaining_d == 16'd0);
`endif
            m_tvalid_d = 1'b1;
            state_d    = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (m_axis_tready) begin
          m_tvalid_d  = 1'b0;
          m_tdata_d   = 32'd0;
          m_tkeep_d   = 4'h0;
          m_tlast_d   = 1'b0;
          collected_d = 3'd0;
          word_d      = 32'd0;
          if (remaining_q != 16'd0) begin
            state_d = ST_GATHER;
          end else begin
`ifdef READOUT_PACKER_CHECKSUM_EN
            m_tdata_d  = {8'h5A, seq_q, sum_q};
            m_tkeep_d  = 4'hF;
            m_tlast_d  = 1'b1;
            m_tvalid_d = 1'b1;
            state_d    = ST_TRAILER;
`else
            seq_d   = seq_q + SEQ_WIDTH'(1);
            stat_d  = stat_q + 32'd1;
            state_d = ST_IDLE;
`endif
          end
        end
      end

`ifdef READOUT_PACKER_CHECKSUM_EN
      ST_TRAILER: begin
        if (m_axis_tready) begin
          m_tvalid_d = 1'b0;
          m_tdata_d  = 32'd0;
          m_tkeep_d  = 4'h0;
          m_tlast_d  = 1'b0;
          seq_d      = seq_q + SEQ_WIDTH'(1);
          stat_d     = stat_q + 32'd1;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      tmo_q       <= '0;
      remaining_q <= 16'd0;
      collected_q <= 3'd0;
      word_q      <= 32'd0;
      m_tdata_q   <= 32'd0;
      m_tkeep_q   <= 4'h0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      stat_q      <= 32'd0;
`ifdef READOUT_PACKER_CHECKSUM_EN
      sum_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      tmo_q       <= tmo_d;
      remaining_q <= remaining_d;
      collected_q <= collected_d;
      word_q      <= word_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      stat_q      <= stat_d;
`ifdef READOUT_PACKER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_readout_frame_packer.sv
// Self-checking bench for readout_frame_packer (MAX_PAYLOAD_BYTES=64,
// TIMEOUT_CYCLES=8). The readout buffer is modelled as a byte queue; the
// expected output stream is built from the packetisation rules.
module tb_readout_frame_packer;

  localparam int MAXP = 64;
  localparam int TMO  = 8;
`ifdef READOUT_PACKER_CHECKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif
  localparam int TRL = CKSUM ? 1 : 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk_core = 1'b0;
  logic        clk_core_resn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_data_count;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        cfg_enable;
  logic        cfg_flush;
  logic        status_busy;
  logic [31:0] stat_packet_count;

  readout_frame_packer #(
    .MAX_PAYLOAD_BYTES(MAXP),
    .TIMEOUT_CYCLES(TMO),
    .SEQ_WIDTH(8)
  ) dut (
    .clk_core(clk_core),
    .clk_core_resn(clk_core_resn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_data_count(s_data_count),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .cfg_enable(cfg_enable),
    .cfg_flush(cfg_flush),
    .status_busy(status_busy),
    .stat_packet_count(stat_packet_count)
  );

  always #5 clk_core = ~clk_core;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;
  int          rdy_pct = 100;
  int          vld_pct = 100;
  logic [7:0]  src_q[$];
  logic [7:0]  bq[$];
  word_t       exp_q[$];
  word_t       got_q[$];
  logic [7:0]  m_seq = 8'd0;
  int          m_pkts = 0;
  bit          stall_pending = 1'b0;
  word_t       held;

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {d, k, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packetiser: splits a batch already sitting in the buffer into
  // packets of min(available, MAXP) bytes and lists every output word.
  task automatic model_batch(input logic [7:0] b[$]);
    int pos = 0;
    int len, n;
    logic [31:0] d;
    logic [15:0] sum;
    while (pos < b.size()) begin
      len = (b.size() - pos > MAXP) ? MAXP : b.size() - pos;
      exp_q.push_back(mk({8'hA5, m_seq, 16'(len)}, 4'hF, 1'b0));
      sum = 16'd0;
      for (int i = 0; i < len; i += 4) begin
        n = (len - i > 4) ? 4 : len - i;
        d = 32'd0;
        for (int k = 0; k < n; k++) begin
          d[8*k +: 8] = b[pos + i + k];
          sum += 16'(b[pos + i + k]);
        end
        exp_q.push_back(mk(d, 4'((1 << n) - 1), !CKSUM && (i + n == len)));
      end
      if (CKSUM) exp_q.push_back(mk({8'h5A, m_seq, sum}, 4'hF, 1'b1));
      m_seq++;
      m_pkts++;
      pos += len;
    end
  endtask

  task automatic load(input logic [7:0] b[$]);
    got_q.delete();
    exp_q.delete();
    model_batch(b);
    foreach (b[i]) src_q.push_back(b[i]);
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  // One clock: at the falling edge, check stall stability, drive inputs for
  // the next rising edge and record the transfers that edge will perform.
  task automatic tick();
    word_t cur;
    @(negedge clk_core);
    cur = mk(m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    if (stall_pending)
      chk("axis_stable", {m_axis_tvalid, cur}, {1'b1, held});
    m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
    s_axis_tvalid = (src_q.size() != 0) && (int'($urandom_range(99)) < vld_pct);
    s_axis_tdata  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    s_data_count  = 32'(src_q.size());
    if (s_axis_tvalid && s_axis_tready) void'(src_q.pop_front());
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
    stall_pending = m_axis_tvalid && !m_axis_tready;
    held = cur;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int budget = 400 + 40 * exp_q.size();
    while ((got_q.size() < exp_q.size() || src_q.size() != 0 || status_busy) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(n < budget), 64'd1);
    chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_stat"}, 64'(stat_packet_count), 64'(m_pkts));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_outs"},
        64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready, status_busy}),
        64'd0);
    chk({tag, "_stat"}, 64'(stat_packet_count), 64'd0);
  endtask

  initial begin
    int t;
    clk_core_resn = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_data_count  = 32'd0;
    m_axis_tready = 1'b0;
    cfg_enable    = 1'b0;
    cfg_flush     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_outputs_zero("reset");
    clk_core_resn = 1'b1;
    repeat (2) tick();
    chk("post_reset_busy", 64'(status_busy), 64'd0);

    // Full 64-byte packet, incrementing bytes
    cfg_enable = 1'b1;
    bq.delete();
    for (int i = 0; i < 64; i++) bq.push_back(8'(i));
    load(bq);
    drain("full64");
    if (got_q.size() > 16) begin
      chk("full64_hdr", 64'(got_q[0].data), 64'h00000000_A5000040);
      chk("full64_w1", 64'(got_q[1].data), 64'h00000000_03020100);
      chk("full64_w16_keep", 64'(got_q[16].keep), 64'hF);
      chk("full64_w16_last", 64'(got_q[16].last), 64'(!CKSUM));
    end
    chk("full64_stat1", 64'(stat_packet_count), 64'd1);

    // Short packet forced by the idle timeout
    bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    load(bq);
    t = 0;
    while (got_q.size() == 0 && t < 40) begin
      tick();
      t++;
    end
    chk("tmo_latency", 64'(t), 64'd10);
    drain("tmo5");
    if (got_q.size() > 2) begin
      chk("tmo5_hdr", 64'(got_q[0].data), 64'h00000000_A5010005);
      chk("tmo5_w1", 64'(got_q[1]), 64'(mk(32'h14131211, 4'hF, 1'b0)));
      chk("tmo5_w2", 64'(got_q[2]), 64'(mk(32'h00000015, 4'h1, !CKSUM)));
    end

    // Flush with random back-pressure and source gaps
    cfg_flush = 1'b1;
    rdy_pct = 50;
    vld_pct = 70;
    rand_bytes(3);
    load(bq);
    drain("flush3");
    if (got_q.size() > 0)
      chk("flush3_len", 64'(got_q[0].data[15:0]), 64'd3);
    for (int r = 0; r < 6; r++) begin
      rand_bytes(int'($urandom_range(150, 1)));
      load(bq);
      drain($sformatf("rnd%0d", r));
    end

    // cfg_enable drops mid-packet: packet completes, next one waits
    cfg_flush = 1'b0;
    rdy_pct = 70;
    vld_pct = 100;
    rand_bytes(70);
    load(bq);
    t = 0;
    while (got_q.size() == 0 && t < 100) begin
      tick();
      t++;
    end
    cfg_enable = 1'b0;
    t = 0;
    while (got_q.size() < 17 + TRL && t < 600) begin
      tick();
      t++;
    end
    repeat (40) tick();
    chk("endrop_words", 64'(got_q.size()), 64'(17 + TRL));
    chk("endrop_idle", 64'(status_busy), 64'd0);
    chk("endrop_left", 64'(src_q.size()), 64'd6);
    cfg_enable = 1'b1;
    drain("endrop");

    // Asynchronous reset while gathering payload
    cfg_flush = 1'b1;
    rdy_pct = 100;
    vld_pct = 30;
    rand_bytes(40);
    load(bq);
    t = 0;
    while (!s_axis_tready && t < 50) begin
      tick();
      t++;
    end
    chk("reach_gather", 64'(s_axis_tready), 64'd1);
    #3;
    clk_core_resn = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    src_q.delete();
    got_q.delete();
    exp_q.delete();
    m_seq = 8'd0;
    m_pkts = 0;
    stall_pending = 1'b0;
    repeat (2) tick();
    clk_core_resn = 1'b1;
    rdy_pct = 80;
    vld_pct = 90;
    rand_bytes(4);
    load(bq);
    drain("post_rst");
    if (got_q.size() > 0)
      chk("post_rst_hdr", 64'(got_q[0].data), 64'h00000000_A5000004);

    // 256 further short packets: sequence field wraps 0xFF -> 0x00
    for (int p = 0; p < 256; p++) begin
      rand_bytes(int'($urandom_range(8, 1)));
      load(bq);
      drain($sformatf("pk%0d", p));
    end
    chk("stat257", 64'(stat_packet_count), 64'd257);
    if (got_q.size() > 0)
      chk("seq_wrap_hdr", 64'(got_q[0].data[31:16]), 64'h0000_0000_0000_A500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
